default_read_slave: RTL and testbench
=====================================

# default_read_slave

Virtual slave S2 of the AXI interconnect read path. It accepts any read request that the AR decoder steers to it for an unmapped address. For each request it returns a full-length burst of DECERR beats on the R channel, so the requesting master always completes its transaction. Its R outputs feed the R arbiter as slave 2, which drives `RREADY_S2` back to it. It also keeps a saturating count of decode errors and the address of the most recent offending request, for debug.

## Interface
- `ID_WIDTH`, 8: interconnect-side ID width. Bit 4 selects the master; bits 3:0 are the master's ID.
- `DATA_WIDTH`, 32: R data width.
- `LEN_WIDTH`, 4: ARLEN width. A burst is ARLEN+1 beats.
- `DATA_PATTERN`, 32'h0: constant driven on RDATA for every beat.
- `CNT_WIDTH`, 16: width of the error counter.

Ports:
- `clk` in 1: the single clock. All logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `ARID_S2` in ID_WIDTH: request ID.
- `ARADDR_S2` in 32: request address.
- `ARLEN_S2` in LEN_WIDTH: burst length minus 1.
- `ARSIZE_S2` in 3, `ARBURST_S2` in 2: accepted and ignored.
- `ARVALID_S2` in 1: request valid.
- `ARREADY_S2` out 1: request accepted.
- `RID_S2` out ID_WIDTH: returned ID, equal to the captured ARID.
- `RDATA_S2` out DATA_WIDTH: always DATA_PATTERN.
- `RRESP_S2` out 2: always 2'b11 (DECERR).
- `RLAST_S2` out 1: final beat of the burst.
- `RVALID_S2` out 1: beat valid.
- `RREADY_S2` in 1: beat accepted, from the R decoder path.
- `DECERR_CNT` out CNT_WIDTH: number of completed error bursts, saturating.
- `DECERR_ADDR` out 32: ARADDR of the most recently accepted request.

## Operation
- State machine with three states: RESET_WAIT, IDLE, RESP.
  - RESET_WAIT is forced while `rst`=0 and moves to IDLE on the first rising edge after `rst` goes high.
  - IDLE: `ARREADY_S2`=1 and `RVALID_S2`=0.
  - RESP: `ARREADY_S2`=0 and `RVALID_S2`=1.
- An AR handshake is `ARVALID_S2 && ARREADY_S2` at a rising edge. On an AR handshake:
  - capture ARID into the ID register and ARLEN into the length register;
  - clear the beat counter to 0;
  - capture ARADDR into `DECERR_ADDR`;
  - go to RESP.
- An R handshake is `RVALID_S2 && RREADY_S2` at a rising edge.
- In RESP:
  - `RLAST_S2` = (beat counter == captured length).
  - On an R handshake with RLAST=0, the beat counter increments by 1 and the state stays RESP.
  - On an R handshake with RLAST=1, go to IDLE and increment `DECERR_CNT`, unless it is already all-ones, in which case it holds.
- The beat counter is LEN_WIDTH bits and never wraps: it stops at the captured length.
- Only one transaction is outstanding at a time. No AR is accepted in RESP.
- ARSIZE and ARBURST have no effect. Every beat carries DATA_PATTERN with RRESP DECERR.
- The address and length registers are never cleared after reset; they update only on an AR handshake.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - `ARREADY_S2`=0, `RVALID_S2`=0, `RLAST_S2`=0;
  - `RID_S2`=0, `DECERR_CNT`=0, `DECERR_ADDR`=0;
  - `RRESP_S2`=2'b11, `RDATA_S2`=DATA_PATTERN.
- `ARREADY_S2` first rises one cycle after reset release.
- Latency: an AR handshake at edge N puts the first beat (`RVALID_S2`=1) on the outputs right after edge N. Minimum burst time is ARLEN+1 cycles.
- While `RVALID_S2`=1 and `RREADY_S2`=0, `RID_S2`, `RLAST_S2`, `RDATA_S2` and `RRESP_S2` hold stable. `RVALID_S2` never drops before the handshake.
- The last R handshake at edge M returns the block to IDLE, and `ARREADY_S2`=1 from edge M onward. The next AR can therefore be accepted at edge M+1, giving one dead cycle between bursts.
- All outputs are driven from registers. No combinational path runs from ARVALID or RREADY to any output.
- Reset asserted mid-burst aborts the burst immediately. All outputs take their reset values and the counter is not incremented.
- `DECERR_CNT` updates on the edge of the last R handshake and is visible in the next cycle.

## Test plan
- Reset release with `ARVALID_S2`=0:
  - `ARREADY_S2` is 0 during reset and becomes 1 one cycle after release;
  - all other outputs hold their reset values.
- Single beat: ARID=8'h13, ARLEN=0, ARADDR=32'hFFFF_0000, RREADY held at 1 →
  - one beat with RID=8'h13, RRESP=2'b11, RLAST=1 and RDATA=DATA_PATTERN, one cycle after the AR handshake;
  - then `DECERR_CNT`=1 and `DECERR_ADDR`=32'hFFFF_0000.
- Burst with backpressure: ARLEN=3, RREADY toggling 1,0,0,1,1,0,1 →
  - exactly 4 beats, with RLAST high only on the 4th;
  - outputs stay stable through every stall cycle;
  - `ARREADY_S2` stays 0 for the whole burst.
- Back-to-back: a second ARVALID is held high during the first burst →
  - it is not accepted until the cycle after the first burst's last beat;
  - the second burst's RID matches the second ARID.
- Mid-burst reset: rst pulled low on beat 2 of an ARLEN=7 burst →
  - all outputs go to reset values at once and `DECERR_CNT` does not increment;
  - after release, a new ARLEN=0 request completes normally.
- Counter saturation with CNT_WIDTH=2: complete 5 bursts → `DECERR_CNT` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/default_read_slave.sv
// Default (unmapped-address) read slave: answers every AR with a full-length
// DECERR burst and records the error count and the last offending address.
module default_read_slave #(
  parameter int                    ID_WIDTH     = 8,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    LEN_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = {DATA_WIDTH{1'b0}},
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID_S2,
  input  logic [31:0]           ARADDR_S2,
  input  logic [LEN_WIDTH-1:0]  ARLEN_S2,
  input  logic [2:0]            ARSIZE_S2,
  input  logic [1:0]            ARBURST_S2,
  input  logic                  ARVALID_S2,
  output logic                  ARREADY_S2,
  output logic [ID_WIDTH-1:0]   RID_S2,
  output logic [DATA_WIDTH-1:0] RDATA_S2,
  output logic [1:0]            RRESP_S2,
  output logic                  RLAST_S2,
  output logic                  RVALID_S2,
  input  logic                  RREADY_S2,
  output logic [CNT_WIDTH-1:0]  DECERR_CNT,
  output logic [31:0]           DECERR_ADDR
);

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    IDLE       = 2'd1,
    RESP       = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]    rid_q, rid_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [LEN_WIDTH-1:0]   beat_inc_s;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic                   ar_hs_s;
  logic                   r_hs_s;
  logic                   unused_s;

  assign ar_hs_s    = ARVALID_S2 & arready_q;
  assign r_hs_s     = rvalid_q & RREADY_S2;
  assign beat_inc_s = beat_q + LEN_WIDTH'(1);
  assign unused_s   = ^{ARSIZE_S2, ARBURST_S2};

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_WAIT;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= {ID_WIDTH{1'b0}};
      len_q     <= {LEN_WIDTH{1'b0}};
      beat_q    <= {LEN_WIDTH{1'b0}};
      cnt_q     <= {CNT_WIDTH{1'b0}};
      addr_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_WAIT: state_d = IDLE;
      IDLE: begin
        if (ar_hs_s) state_d = RESP;
        else         state_d = IDLE;
      end
      RESP: begin
        if (r_hs_s && rlast_q) state_d = IDLE;
        else                   state_d = RESP;
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  // Next values of the registered outputs, so every output comes from a flop
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    len_d     = len_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    case (state_q)
      RESET_WAIT: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
      IDLE: begin
        if (ar_hs_s) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = ARID_S2;
          len_d     = ARLEN_S2;
          beat_d    = {LEN_WIDTH{1'b0}};
          addr_d    = ARADDR_S2;
          rlast_d   = (ARLEN_S2 == {LEN_WIDTH{1'b0}});
        end else begin
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end
      end
      RESP: begin
        if (r_hs_s && rlast_q) begin
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
          else                            cnt_d = cnt_q;
        end else if (r_hs_s) begin
          // RLAST is precomputed for the beat that follows this handshake
          beat_d  = beat_inc_s;
          rlast_d = (beat_inc_s == len_q);
        end else begin
          beat_d  = beat_q;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  assign ARREADY_S2  = arready_q;
  assign RVALID_S2   = rvalid_q;
  assign RLAST_S2    = rlast_q;
  assign RID_S2      = rid_q;
  assign RDATA_S2    = DATA_PATTERN;
  assign RRESP_S2    = 2'b11;
  assign DECERR_CNT  = cnt_q;
  assign DECERR_ADDR = addr_q;

endmodule

// File: tb/tb_default_read_slave.sv
// Directed-plus-random bench for default_read_slave: a burst-level model
// predicts beat count, RLAST position, saturating count and last address.
module tb_default_read_slave;
  localparam int IDW  = 8;
  localparam int DW   = 32;
  localparam int LW   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [DW-1:0] PAT = 32'hA5C3_0F96;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDW-1:0] arid = '0;
  logic [31:0]    araddr = '0;
  logic [LW-1:0]  arlen = '0;
  logic [2:0]     arsize = '0;
  logic [1:0]     arburst = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready = 1'b0;
  logic [CW-1:0]  cnt;
  logic [31:0]    eaddr;

  int          total = 0;
  int          bad = 0;
  int          exp_done = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [6:0]  pat7 = 7'b1011001;
  int          waited;

  default_read_slave #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .DATA_PATTERN(PAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .ARID_S2(arid), .ARADDR_S2(araddr), .ARLEN_S2(arlen),
    .ARSIZE_S2(arsize), .ARBURST_S2(arburst),
    .ARVALID_S2(arvalid), .ARREADY_S2(arready),
    .RID_S2(rid), .RDATA_S2(rdata), .RRESP_S2(rresp),
    .RLAST_S2(rlast), .RVALID_S2(rvalid), .RREADY_S2(rready),
    .DECERR_CNT(cnt), .DECERR_ADDR(eaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_cnt(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_arready"}, arready, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_rid"}, rid, 8'h00);
    chk({tag, "_cnt"}, cnt, 2'd0);
    chk({tag, "_addr"}, eaddr, 32'h0);
    chk({tag, "_rresp"}, rresp, 2'b11);
    chk({tag, "_rdata"}, rdata, PAT);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_arready"}, arready, 1'b1);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_rlast"}, rlast, 1'b0);
    chk({tag, "_cnt"}, cnt, sat_cnt(exp_done));
    chk({tag, "_addr"}, eaddr, exp_addr);
  endtask

  // Called at a negedge; returns at the negedge right after the AR handshake.
  task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr,
                         input logic [LW-1:0] len, output int n);
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = 3'($urandom_range(0, 7));
    arburst = 2'($urandom_range(0, 3));
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", arready, 1'b1);
    exp_addr = addr;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // mode 0: RREADY held high, 1: fixed 1,0,0,1,1,0,1 then high, 2: random
  task automatic r_burst(input logic [IDW-1:0] id, input int len, input int mode);
    int beats = 0;
    int cyc = 0;
    logic rr;
    while (beats <= len && cyc < 300) begin
      chk("rvalid", rvalid, 1'b1);
      chk("arready_busy", arready, 1'b0);
      chk("rid", rid, id);
      chk("rresp", rresp, 2'b11);
      chk("rdata", rdata, PAT);
      chk("rlast", rlast, (beats == len));
      case (mode)
        0:       rr = 1'b1;
        1:       rr = (cyc < 7) ? pat7[cyc] : 1'b1;
        default: rr = 1'($urandom_range(0, 1));
      endcase
      rready = rr;
      if (rr) beats++;
      cyc++;
      @(negedge clk);
    end
    rready = 1'b0;
    chk("r_beats", beats, len + 1);
    exp_done++;
    check_idle("post_burst");
  endtask

  initial begin
    logic [31:0] a1;
    logic [31:0] a2;
    logic [LW-1:0] rl;
    logic [CW-1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    // Reset and release
    repeat (3) @(negedge clk);
    check_reset("in_reset");
    rst = 1'b1;
    #1;
    chk("arready_at_release", arready, 1'b0);
    @(negedge clk);
    check_idle("after_release");
    chk("rid_after_release", rid, 8'h00);

    // Single beat
    send_ar(8'h13, 32'hFFFF_0000, 4'd0, waited);
    r_burst(8'h13, 0, 0);
    chk("single_cnt", cnt, 2'd1);
    chk("single_addr", eaddr, 32'hFFFF_0000);

    // Burst with backpressure
    a1 = $urandom;
    send_ar(8'h05, a1, 4'd3, waited);
    r_burst(8'h05, 3, 1);

    // Back-to-back: second AR held during first burst
    a1 = $urandom;
    a2 = $urandom;
    send_ar(8'h1A, a1, 4'd2, waited);
    arid = 8'h07; araddr = a2; arlen = 4'd1; arvalid = 1'b1;
    r_burst(8'h1A, 2, 2);
    send_ar(8'h07, a2, 4'd1, waited);
    chk("b2b_no_wait", waited, 0);
    r_burst(8'h07, 1, 0);

    // Mid-burst reset on beat 2 of an 8-beat burst
    send_ar(8'h11, 32'h1234_5678, 4'd7, waited);
    rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rvalid", rvalid, 1'b1);
    chk("mid_rlast", rlast, 1'b0);
    rst = 1'b0;
    #1;
    check_reset("mid_reset");
    exp_done = 0;
    exp_addr = 32'h0;
    rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_arready_release", arready, 1'b0);
    @(negedge clk);
    check_idle("mid_after_release");
    send_ar(8'h02, 32'hCAFE_0004, 4'd0, waited);
    r_burst(8'h02, 0, 0);

    // Saturation of the 2-bit counter from a fresh reset
    @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
    exp_addr = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rl = 4'($urandom_range(0, 3));
      send_ar(8'($urandom), $urandom, rl, waited);
      r_burst(arid, int'(rl), 2);
      chk("sat_seq", cnt, sat_seq[i]);
    end

    // Random bursts
    for (int i = 0; i < 8; i++) begin
      rl = 4'($urandom_range(0, 15));
      send_ar(8'($urandom), $urandom, rl, waited);
      r_burst(arid, int'(rl), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
